// File: rtl/dbg_bus_master.sv
// Serial debug bridge: turns UART command bytes into read/write cycles on the CPU memory bus.
// Optional burst-read command 'B' is built when DBG_BUS_MASTER_BURST_EN is defined.
module dbg_bus_master #(
  parameter int unsigned READ_LAT = 1,
  parameter logic [7:0]  ACK_BYTE = 8'h2E,
  parameter logic [7:0]  ERR_BYTE = 8'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] address,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  output logic        read
);

  localparam int unsigned     LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT - 1);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
`ifdef DBG_BUS_MASTER_BURST_EN
  localparam logic [7:0] CMD_B = 8'h42;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_DATA,
`ifdef DBG_BUS_MASTER_BURST_EN
    S_COUNT,
`endif
    S_REQ,
    S_WRITE,
    S_RWAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic [7:0]       cmd;
  logic             granted;
  logic [LAT_W-1:0] lat_cnt;
`ifdef DBG_BUS_MASTER_BURST_EN
  logic [8:0]       burst_left;
`endif

  logic rx_accept;
  assign rx_accept = rx_valid & rx_ready;

  function automatic logic known_cmd(input logic [7:0] b);
`ifdef DBG_BUS_MASTER_BURST_EN
    return (b == CMD_W) || (b == CMD_R) || (b == CMD_B);
`else
    return (b == CMD_W) || (b == CMD_R);
`endif
  endfunction

  // NOTE: every register here, outputs included, is state of one FSM, so all
  // updates are non-blocking and every register gets a value under reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cmd      <= '0;
      granted  <= 1'b0;
      lat_cnt  <= '0;
      rx_ready <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      bus_req  <= 1'b0;
      address  <= '0;
      dout     <= '0;
      read     <= 1'b1;
`ifdef DBG_BUS_MASTER_BURST_EN
      burst_left <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          rx_ready <= 1'b1;
          if (rx_accept) begin
            cmd <= rx_data;
            if (known_cmd(rx_data)) begin
              state <= S_ADDR_H;
            end else begin
              rx_ready <= 1'b0;
              tx_data  <= ERR_BYTE;
              tx_valid <= 1'b1;
              state    <= S_RESP;
            end
          end
        end

        S_ADDR_H: begin
          if (rx_accept) begin
            address[15:8] <= rx_data;
            state         <= S_ADDR_L;
          end
        end

        S_ADDR_L: begin
          if (rx_accept) begin
            address[7:0] <= rx_data;
            if (cmd == CMD_W) begin
              state <= S_DATA;
`ifdef DBG_BUS_MASTER_BURST_EN
            end else if (cmd == CMD_B) begin
              state <= S_COUNT;
`endif
            end else begin
              rx_ready <= 1'b0;
              bus_req  <= 1'b1;
              state    <= S_REQ;
            end
          end
        end

        S_DATA: begin
          if (rx_accept) begin
            dout     <= rx_data;
            rx_ready <= 1'b0;
            bus_req  <= 1'b1;
            state    <= S_REQ;
          end
        end

`ifdef DBG_BUS_MASTER_BURST_EN
        S_COUNT: begin
          if (rx_accept) begin
            // A count byte of zero stands for a full 256-byte burst.
            burst_left <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            rx_ready   <= 1'b0;
            bus_req    <= 1'b1;
            state      <= S_REQ;
          end
        end
`endif

        S_REQ: begin
          // The grant is registered first so the bus cycle starts one clock after it is seen.
          if (granted) begin
            granted <= 1'b0;
            if (cmd == CMD_W) begin
              read  <= 1'b0;
              state <= S_WRITE;
            end else begin
              lat_cnt <= LAT_LOAD;
              state   <= S_RWAIT;
            end
          end else if (bus_gnt) begin
            granted <= 1'b1;
          end
        end

        S_WRITE: begin
          read     <= 1'b1;
          tx_data  <= ACK_BYTE;
          tx_valid <= 1'b1;
          state    <= S_RESP;
        end

        S_RWAIT: begin
          if (lat_cnt == '0) begin
            tx_data  <= din;
            tx_valid <= 1'b1;
            state    <= S_RESP;
`ifdef DBG_BUS_MASTER_BURST_EN
            if (cmd == CMD_B) begin
              address    <= address + 16'd1;
              burst_left <= burst_left - 9'd1;
            end
`endif
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        S_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
`ifdef DBG_BUS_MASTER_BURST_EN
            if (cmd == CMD_B && burst_left != '0) begin
              lat_cnt <= LAT_LOAD;
              state   <= S_RWAIT;
            end else begin
              bus_req  <= 1'b0;
              rx_ready <= 1'b1;
              state    <= S_IDLE;
            end
`else
            bus_req  <= 1'b0;
            rx_ready <= 1'b1;
            state    <= S_IDLE;
`endif
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed self-checking bench for dbg_bus_master with a registered-SRAM bus model.
module tb_dbg_bus_master;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] address;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        read;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:65535];

  // Monitor state, sampled 2 ns after each rising edge.
  int          wr_low;
  logic [15:0] wr_addr;
  logic [7:0]  wr_dout;
  int          req_low;
  int          req_seen;
  int          req_low_snap;

  dbg_bus_master dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .address  (address),
    .dout     (dout),
    .din      (din),
    .read     (read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered SRAM: one cycle from address to din, writes on a granted read=0 cycle.
  always @(posedge clk) begin
    if (!read && bus_gnt) mem[address] <= dout;
    din <= mem[address];
  end

  always begin
    @(posedge clk);
    #2;
    if (!read) begin
      wr_low  = wr_low + 1;
      wr_addr = address;
      wr_dout = dout;
    end
    if (bus_req) req_seen = 1;
    else         req_low  = req_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge after the byte is consumed.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rx_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 32'(n), 32'd0);
    req_low_snap = req_low;
    check(tag, {24'd0, tx_data}, {24'd0, exp});
    tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int bad;
    logic [7:0] held;

    rst = 1'b1;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0; bus_gnt = 1'b0;
    wr_low = 0; req_low = 0; req_seen = 0; req_low_snap = 0;
    mem[16'h0123] = 8'h3C;
    mem[16'h4455] = 8'h99;
    mem[16'h0200] = 8'h5A;
    mem[16'hFFFE] = 8'h11;
    mem[16'hFFFF] = 8'h22;
    mem[16'h0000] = 8'h33;

    // Reset values
    #1 rst = 1'b0;
    #2;
    check("rst_outputs", {rx_ready, tx_valid, bus_req, read}, 4'b0001);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_addr_dout", {8'd0, address, dout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

    // 1: write E6D1 <= A5
    send_byte(8'h57); send_byte(8'hE6); send_byte(8'hD1); send_byte(8'hA5);
    check("wr_bus_req", {31'd0, bus_req}, 32'd1);
    wr_low = 0;
    bus_gnt = 1'b1;
    wait_tx("wr_ack", 8'h2E);
    check("wr_low_cycles", 32'(wr_low), 32'd1);
    check("wr_addr", {16'd0, wr_addr}, 32'hE6D1);
    check("wr_dout", {24'd0, wr_dout}, 32'hA5);
    check("wr_req_drop", {31'd0, bus_req}, 32'd0);
    check("wr_mem", {24'd0, mem[16'hE6D1]}, 32'hA5);
    check("wr_addr_hold", {16'd0, address}, 32'hE6D1);
    bus_gnt = 1'b0;

    // 2: read 0123, latency from grant to tx_valid
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h23);
    wr_low = 0;
    bus_gnt = 1'b1;
    cyc = 0;
    while (!tx_valid && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("rd_latency", 32'(cyc), 32'd3);
    @(negedge clk);
    wait_tx("rd_data", 8'h3C);
    check("rd_no_write", 32'(wr_low), 32'd0);
    bus_gnt = 1'b0;

    // 3: grant delay and tx backpressure
    send_byte(8'h52); send_byte(8'h44); send_byte(8'h55);
    wr_low = 0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid || !read || rx_ready || !bus_req) bad++;
    end
    check("stall_before_gnt", 32'(bad), 32'd0);
    bus_gnt = 1'b1;
    cyc = 0;
    while (!tx_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    held = tx_data;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== held || rx_ready) bad++;
    end
    check("tx_stall_stable", 32'(bad), 32'd0);
    wait_tx("bp_data", 8'h99);
    bus_gnt = 1'b0;

    // 4: unknown command, then a normal read
    req_seen = 0;
    send_byte(8'h00);
    wait_tx("bad_cmd", 8'h3F);
    check("bad_no_req", 32'(req_seen), 32'd0);
    send_byte(8'h52); send_byte(8'h02); send_byte(8'h00);
    bus_gnt = 1'b1;
    wait_tx("after_bad_rd", 8'h5A);
    bus_gnt = 1'b0;

    // 5: reset during RWAIT (grant edge, then one edge to enter RWAIT)
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h23);
    bus_gnt = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ctrl", {rx_ready, tx_valid, bus_req, read}, 4'b0001);
    check("mid_rst_addr", {8'd0, address, dout}, 32'd0);
    bus_gnt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_valid) bad++;
    end
    check("mid_rst_no_tx", 32'(bad), 32'd0);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h77);
    bus_gnt = 1'b1;
    wait_tx("post_rst_ack", 8'h2E);
    check("post_rst_mem", {24'd0, mem[16'h0010]}, 32'h77);
    bus_gnt = 1'b0;

    // 6: burst 42,FF,FE,03
`ifdef DBG_BUS_MASTER_BURST_EN
    send_byte(8'h42); send_byte(8'hFF); send_byte(8'hFE); send_byte(8'h03);
    bus_gnt = 1'b1;
    req_low = 0;
    wait_tx("burst_0", 8'h11);
    wait_tx("burst_1", 8'h22);
    wait_tx("burst_2", 8'h33);
    check("burst_req_held", 32'(req_low_snap), 32'd0);
    check("burst_req_drop", {31'd0, bus_req}, 32'd0);
    bus_gnt = 1'b0;
`else
    send_byte(8'h42);
    wait_tx("no_burst_42", 8'h3F);
    send_byte(8'hFF);
    wait_tx("no_burst_ff", 8'h3F);
    send_byte(8'hFE);
    wait_tx("no_burst_fe", 8'h3F);
    send_byte(8'h03);
    wait_tx("no_burst_03", 8'h3F);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
